// File: rtl/aurora_pkg.sv
// Shared types and constants for the Aurora TX path.
// State encoding and arbitration mode values.
package aurora_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_GNT0  = 2'd1;
   localparam state_t ST_GNT1  = 2'd2;
   localparam state_t ST_FLUSH = 2'd3;

   localparam logic [1:0] MODE_HOST = 2'd0;
   localparam logic [1:0] MODE_LOOP = 2'd1;
   localparam logic [1:0] MODE_RR   = 2'd2;
   localparam logic [1:0] MODE_OFF  = 2'd3;

endpackage

// File: rtl/aurora_tx_arb.sv
// Packet-boundary arbiter for the shared Aurora TX stream.
// Optional statistics counters: AURORA_TX_ARB_STATS_EN.
module aurora_tx_arb
   import aurora_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  m_axis_aclk,
   input  logic                  m_axis_aresetn,
   input  logic                  s0_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
   input  logic                  s0_axis_tlast,
   output logic                  s0_axis_tready,
   input  logic                  s1_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
   input  logic                  s1_axis_tlast,
   output logic                  s1_axis_tready,
   output logic                  m_axis_tvalid,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   input  logic [1:0]            mode,
   input  logic                  channel_up,
   output logic [1:0]            grant,
   output logic                  flushing,
   output logic [31:0]           pkt_cnt0,
   output logic [31:0]           pkt_cnt1,
   output logic [31:0]           flush_cnt
);

   state_t state;
   state_t state_nxt;
   logic   last;
   logic   last_nxt;
   logic   flush_src;
   logic   flush_src_nxt;

   // Next-state decode and combinational stream routing.
   always_comb begin
      state_nxt      = state;
      last_nxt       = last;
      flush_src_nxt  = flush_src;
      m_axis_tvalid  = 1'b0;
      m_axis_tdata   = '0;
      m_axis_tlast   = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      grant          = 2'b00;
      flushing       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (channel_up) begin
               unique case (mode)
                  MODE_HOST: if (s0_axis_tvalid) state_nxt = ST_GNT0;
                  MODE_LOOP: if (s1_axis_tvalid) state_nxt = ST_GNT1;
                  MODE_RR: begin
                     if (s0_axis_tvalid && s1_axis_tvalid)
                        state_nxt = last ? ST_GNT0 : ST_GNT1;
                     else if (s0_axis_tvalid)
                        state_nxt = ST_GNT0;
                     else if (s1_axis_tvalid)
                        state_nxt = ST_GNT1;
                  end
                  default: state_nxt = ST_IDLE;
               endcase
            end
         end
         ST_GNT0: begin
            grant = 2'b01;
            if (!channel_up) begin
               state_nxt     = ST_FLUSH;
               flush_src_nxt = 1'b0;
            end else begin
               m_axis_tvalid  = s0_axis_tvalid;
               m_axis_tdata   = s0_axis_tdata;
               m_axis_tlast   = s0_axis_tlast;
               s0_axis_tready = m_axis_tready;
               if (s0_axis_tvalid && m_axis_tready && s0_axis_tlast) begin
                  state_nxt = ST_IDLE;
                  last_nxt  = 1'b0;
               end
            end
         end
         ST_GNT1: begin
            grant = 2'b10;
            if (!channel_up) begin
               state_nxt     = ST_FLUSH;
               flush_src_nxt = 1'b1;
            end else begin
               m_axis_tvalid  = s1_axis_tvalid;
               m_axis_tdata   = s1_axis_tdata;
               m_axis_tlast   = s1_axis_tlast;
               s1_axis_tready = m_axis_tready;
               if (s1_axis_tvalid && m_axis_tready && s1_axis_tlast) begin
                  state_nxt = ST_IDLE;
                  last_nxt  = 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            flushing = 1'b1;
            if (!flush_src) begin
               s0_axis_tready = 1'b1;
               if (s0_axis_tvalid && s0_axis_tlast)
                  state_nxt = ST_IDLE;
            end else begin
               s1_axis_tready = 1'b1;
               if (s1_axis_tvalid && s1_axis_tlast)
                  state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   // FSM, round-robin history and flush source registers.
   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         state     <= ST_IDLE;
         last      <= 1'b1;
         flush_src <= 1'b0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         flush_src <= flush_src_nxt;
      end
   end

`ifdef AURORA_TX_ARB_STATS_EN
   logic [31:0] cnt0;
   logic [31:0] cnt1;
   logic [31:0] cntf;
   logic        fwd0;
   logic        fwd1;
   logic        flush_in;

   assign fwd0 = (state == ST_GNT0) && channel_up &&
                 s0_axis_tvalid && m_axis_tready && s0_axis_tlast;
   assign fwd1 = (state == ST_GNT1) && channel_up &&
                 s1_axis_tvalid && m_axis_tready && s1_axis_tlast;
   assign flush_in = ((state == ST_GNT0) || (state == ST_GNT1)) &&
                     !channel_up;

   // Forwarded-frame and flush-entry counters, free-running wrap.
   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         cnt0 <= '0;
         cnt1 <= '0;
         cntf <= '0;
      end else begin
         if (fwd0)     cnt0 <= cnt0 + 32'd1;
         if (fwd1)     cnt1 <= cnt1 + 32'd1;
         if (flush_in) cntf <= cntf + 32'd1;
      end
   end

   assign pkt_cnt0  = cnt0;
   assign pkt_cnt1  = cnt1;
   assign flush_cnt = cntf;
`else
   assign pkt_cnt0  = '0;
   assign pkt_cnt1  = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_aurora_tx_arb.sv
// Scoreboard bench for aurora_tx_arb.
// Counter expectations follow AURORA_TX_ARB_STATS_EN.
module tb_aurora_tx_arb;
   import aurora_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tready;
   logic [31:0] s0_tdata = '0;
   logic        s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tready;
   logic [31:0] s1_tdata = '0;
   logic        m_tvalid, m_tlast;
   logic [31:0] m_tdata;
   logic        m_tready = 1'b1;
   logic [1:0]  mode = MODE_OFF;
   logic        channel_up = 1'b1;
   logic [1:0]  grant;
   logic        flushing;
   logic [31:0] pkt_cnt0, pkt_cnt1, flush_cnt;

   int vectors = 0;
   int miscompares = 0;

   logic [32:0] q0[$];
   logic [32:0] q1[$];
   logic [32:0] exq[$];
   bit en0 = 0, en1 = 0;
   bit h0, h1;

   always #5 clk = ~clk;

   aurora_tx_arb #(.DATA_WIDTH(32)) dut (
      .m_axis_aclk(clk),
      .m_axis_aresetn(rst_n),
      .s0_axis_tvalid(s0_tvalid),
      .s0_axis_tdata(s0_tdata),
      .s0_axis_tlast(s0_tlast),
      .s0_axis_tready(s0_tready),
      .s1_axis_tvalid(s1_tvalid),
      .s1_axis_tdata(s1_tdata),
      .s1_axis_tlast(s1_tlast),
      .s1_axis_tready(s1_tready),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tdata(m_tdata),
      .m_axis_tlast(m_tlast),
      .m_axis_tready(m_tready),
      .mode(mode),
      .channel_up(channel_up),
      .grant(grant),
      .flushing(flushing),
      .pkt_cnt0(pkt_cnt0),
      .pkt_cnt1(pkt_cnt1),
      .flush_cnt(flush_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef AURORA_TX_ARB_STATS_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   task automatic refresh();
      if (en0 && q0.size() > 0) begin
         s0_tvalid = 1'b1;
         {s0_tlast, s0_tdata} = q0[0];
      end else begin
         s0_tvalid = 1'b0;
         s0_tlast  = 1'b0;
         s0_tdata  = '0;
      end
      if (en1 && q1.size() > 0) begin
         s1_tvalid = 1'b1;
         {s1_tlast, s1_tdata} = q1[0];
      end else begin
         s1_tvalid = 1'b0;
         s1_tlast  = 1'b0;
         s1_tdata  = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic load(input int src, input logic [31:0] d,
                       input logic l, input bit expect_fwd);
      if (src == 0) q0.push_back({l, d});
      else q1.push_back({l, d});
      if (expect_fwd) exq.push_back({l, d});
   endtask

   task automatic chk_outs_zero(input string name);
      chk(name, {25'b0, m_tvalid, m_tlast, m_tdata, s0_tready,
                 s1_tready, grant, flushing}, 64'd0);
      chk({name, "_cnt"}, {pkt_cnt0, pkt_cnt1 | flush_cnt}, 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en0 = 0;
      en1 = 0;
      q0.delete();
      q1.delete();
      exq.delete();
      m_tready = 1'b1;
      channel_up = 1'b1;
      mode = MODE_OFF;
      refresh();
      neg();
      chk_outs_zero("reset_outs");
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Source models: hold the head word, advance after a handshake.
   initial begin
      forever begin
         @(negedge clk);
         h0 = s0_tvalid && s0_tready;
         h1 = s1_tvalid && s1_tready;
         @(posedge clk);
         #1;
         if (h0 && q0.size() > 0) void'(q0.pop_front());
         if (h1 && q1.size() > 0) void'(q1.pop_front());
         refresh();
      end
   end

   // Monitor: every accepted output beat must match the scoreboard head.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && m_tvalid && m_tready) begin
            if (exq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL beat_extra: got %0h want none",
                        {m_tlast, m_tdata});
            end else begin
               e = exq.pop_front();
               chk("beat", {31'b0, m_tlast, m_tdata}, {31'b0, e});
            end
         end
      end
   end

   initial begin
      logic [11:0] pat;
      bit s0_seen;

      tick();
      do_reset();

      // Host-only 3-word frame.
      mode = MODE_HOST;
      load(0, 32'hA000_0001, 1'b0, 1);
      load(0, 32'hA000_0002, 1'b0, 1);
      load(0, 32'hA000_0003, 1'b1, 1);
      en0 = 1;
      refresh();
      neg();
      chk("t1_idle_grant", {62'b0, grant}, 64'd0);
      chk("t1_idle_valid", {63'b0, m_tvalid}, 64'd0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         neg();
         chk("t1_grant", {62'b0, grant}, 64'd1);
      end
      tick();
      neg();
      chk("t1_grant_end", {62'b0, grant}, 64'd0);
      chk("t1_pkt_cnt0", {32'b0, pkt_cnt0}, {32'b0, stat(32'd1)});

      // Round-robin, both sources always valid.
      do_reset();
      mode = MODE_RR;
      load(0, 32'hB000_0001, 1'b0, 1);
      load(0, 32'hB000_0002, 1'b1, 1);
      load(1, 32'hC000_0001, 1'b0, 1);
      load(1, 32'hC000_0002, 1'b1, 1);
      load(0, 32'hB000_0003, 1'b0, 1);
      load(0, 32'hB000_0004, 1'b1, 1);
      load(1, 32'hC000_0003, 1'b0, 1);
      load(1, 32'hC000_0004, 1'b1, 1);
      en0 = 1;
      en1 = 1;
      refresh();
      pat = '0;
      for (int i = 0; i < 12; i++) begin
         if (i != 0) tick();
         neg();
         pat = {pat[10:0], m_tvalid};
      end
      chk("t2_valid_pattern", {52'b0, pat}, 64'h6DB);
      tick();
      neg();
      chk("t2_pkt_cnt0", {32'b0, pkt_cnt0}, {32'b0, stat(32'd2)});
      chk("t2_pkt_cnt1", {32'b0, pkt_cnt1}, {32'b0, stat(32'd2)});

      // Mode switched mid-frame.
      do_reset();
      mode = MODE_HOST;
      load(0, 32'hA100_0001, 1'b0, 1);
      load(0, 32'hA100_0002, 1'b0, 1);
      load(0, 32'hA100_0003, 1'b1, 1);
      load(1, 32'hC100_0001, 1'b0, 1);
      load(1, 32'hC100_0002, 1'b1, 1);
      load(0, 32'hB100_0001, 1'b0, 0);
      load(0, 32'hB100_0002, 1'b1, 0);
      en0 = 1;
      en1 = 1;
      refresh();
      tick();
      tick();
      mode = MODE_LOOP;
      tick();
      tick();
      s0_seen = 0;
      for (int i = 0; i < 8; i++) begin
         neg();
         if (s0_tready) s0_seen = 1;
         tick();
      end
      chk("t3_s0_ready_after", {63'b0, s0_seen}, 64'd0);
      chk("t3_s0_left", q0.size(), 64'd2);
      chk("t3_s1_left", q1.size(), 64'd0);

      // Channel drop after word 2 of a 5-word loopback frame.
      do_reset();
      mode = MODE_LOOP;
      load(1, 32'hD000_0001, 1'b0, 1);
      load(1, 32'hD000_0002, 1'b0, 1);
      load(1, 32'hD000_0003, 1'b0, 0);
      load(1, 32'hD000_0004, 1'b0, 0);
      load(1, 32'hD000_0005, 1'b1, 0);
      en1 = 1;
      refresh();
      tick();
      tick();
      tick();
      channel_up = 1'b0;
      neg();
      chk("t4_drop_valid", {63'b0, m_tvalid}, 64'd0);
      chk("t4_drop_ready", {63'b0, s1_tready}, 64'd0);
      tick();
      neg();
      chk("t4_flushing", {63'b0, flushing}, 64'd1);
      chk("t4_flush_grant", {62'b0, grant}, 64'd0);
      chk("t4_flush_ready", {62'b0, s1_tready, m_tvalid}, 64'd2);
      tick();
      tick();
      tick();
      neg();
      chk("t4_flush_done", {63'b0, flushing}, 64'd0);
      chk("t4_s1_ready_idle", {63'b0, s1_tready}, 64'd0);
      chk("t4_s1_left", q1.size(), 64'd0);
      chk("t4_flush_cnt", {32'b0, flush_cnt}, {32'b0, stat(32'd1)});
      channel_up = 1'b1;

      // Output stall for 10 cycles mid-frame.
      do_reset();
      mode = MODE_HOST;
      load(0, 32'hE000_0001, 1'b0, 1);
      load(0, 32'hE000_0002, 1'b0, 1);
      load(0, 32'hE000_0003, 1'b0, 1);
      load(0, 32'hE000_0004, 1'b1, 1);
      en0 = 1;
      refresh();
      tick();
      tick();
      tick();
      m_tready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         neg();
         chk("t5_stall_valid", {63'b0, m_tvalid}, 64'd1);
         chk("t5_stall_data", {32'b0, m_tdata}, 64'hE000_0003);
         tick();
      end
      chk("t5_stall_held", q0.size(), 64'd2);
      m_tready = 1'b1;
      tick();
      tick();
      neg();
      chk("t5_s0_left", q0.size(), 64'd0);
      chk("t5_pkt_cnt0", {32'b0, pkt_cnt0}, {32'b0, stat(32'd1)});

      // Reset mid-frame, then mode off with both sources valid.
      do_reset();
      mode = MODE_HOST;
      load(0, 32'hF000_0001, 1'b0, 1);
      load(0, 32'hF000_0002, 1'b0, 1);
      load(0, 32'hF000_0003, 1'b0, 0);
      load(0, 32'hF000_0004, 1'b1, 0);
      en0 = 1;
      refresh();
      tick();
      tick();
      tick();
      #1;
      rst_n = 1'b0;
      neg();
      chk_outs_zero("t6_in_reset");
      q0.delete();
      mode = MODE_OFF;
      load(0, 32'h6000_0001, 1'b0, 0);
      load(0, 32'h6000_0002, 1'b1, 0);
      load(1, 32'h7000_0001, 1'b0, 0);
      load(1, 32'h7000_0002, 1'b1, 0);
      en1 = 1;
      refresh();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         neg();
         chk("t6_no_grant", {60'b0, grant, m_tvalid,
                             s0_tready | s1_tready}, 64'd0);
      end
      chk("t6_q0_kept", q0.size(), 64'd2);
      chk("t6_q1_kept", q1.size(), 64'd2);

      tick();
      chk("scoreboard_empty", exq.size(), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
